multicycle_controller: RTL
==========================

# multicycle_controller

Moore state-machine control unit for the multicycle variant of the MIPS core. It reuses one ALU and a single unified instruction/data memory port across several cycles per instruction, so memory accesses are sequenced through one port. It decodes `Op`/`Funct` and drives every datapath select and write strobe. It sits inside the CPU next to the datapath, and the `MemWrite` output goes to the shared memory.

## Interface
Parameters:
- none; all encodings (states, opcodes, funct, ALUOp, ALUControl) are constants in `mc_pkg`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `Op`  in  6  instruction opcode, from the instruction register `[31:26]`
- `Funct`  in  6  instruction funct field `[5:0]`
- `Zero`  in  1  ALU zero flag, valid in the cycle it is used
- `PCEn`  out  1  PC register enable
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  1  write register select: 0 = rt, 1 = rd
- `MemtoReg`  out  1  write-back select: 0 = ALUOut, 1 = Data
- `RegWrite`  out  1  register file write strobe
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = A
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `ALUControl`  out  3  ALU operation code
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `State`  out  4  current state, for debug and the bench

## Operation
States and encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.

Transitions:
- FETCH → DECODE.
- DECODE dispatches on `Op`:
  - lw `100011` / sw `101011` → MEMADR
  - R-type `000000` → EXECUTE
  - beq `000100` → BRANCH
  - addi `001000` → ADDIEXEC
  - j `000010` → JUMP
  - any other opcode → FETCH (illegal opcode becomes a 2-cycle no-op)
- MEMADR → MEMREAD if lw, MEMWRITE if sw.
- MEMREAD → MEMWB.
- EXECUTE → ALUWB.
- ADDIEXEC → ADDIWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- Encodings 12–15 → FETCH.

Outputs per state (any output not listed is 0):
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMREAD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWRITE: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- JUMP: PCSrc=10, PCWrite=1.

Derived signals:
- `PCEn = PCWrite | (Branch & Zero) [| (BranchNe & ~Zero)]`; the bracketed term exists only under the configuration macro.

ALU decoder (combinational):
- ALUOp 00 → 010 (add); ALUOp 01 → 110 (sub).
- ALUOp 10 decodes `Funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
- Unknown `Funct` → 010. The instruction still completes and writes rd.
- ALUOp 11 → 010.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from `State`, except that `PCEn` also depends on `Zero`.
- Reset behaviour:
  - Asserting `reset` (low) forces State = FETCH immediately, with no clock required.
  - While `reset` is low, `PCEn`, `IRWrite`, `RegWrite` and `MemWrite` are forced to 0. The remaining outputs take their FETCH values.
  - The first real fetch happens on the first rising edge after deassertion.
- Reset asserted mid-instruction abandons the instruction. Any write strobe already issued in an earlier cycle is not undone.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Exactly one memory access occurs per FETCH, MEMREAD or MEMWRITE cycle. `MemWrite` is high for exactly one cycle per sw.

## Configuration
- `MCCTRL_BNE_EN` defined:
  - DECODE sends bne `000101` to BRANCH.
  - An internal `BranchNe` flag is set for bne, and BRANCH then asserts `PCEn` when `Zero`=0.
- `MCCTRL_BNE_EN` undefined: `000101` is illegal and returns to FETCH after DECODE.

## Structure
- `mc_pkg` holds:
  - state enum (4-bit)
  - opcode constants
  - funct constants
  - ALUOp constants
  - ALUControl constants
- Sub-module `alu_decoder` (ALUOp, Funct → ALUControl), instantiated once. The FSM and strobe gating live in `multicycle_controller`.

## Test plan
- Reset low for 3 cycles, release → State=0 and all four strobes 0 during reset. IRWrite=1 and PCEn=1 in the first post-reset cycle; State=1 the next cycle.
- lw `Op`=100011 → state sequence 0,1,2,3,4,0. IorD=1 only in state 3. RegWrite=1 and MemtoReg=1 only in state 4.
- sw then R-type sub (`Funct`=100010) → MemWrite is a single-cycle pulse in state 5. ALUControl=110 in state 6; RegDst=1 and RegWrite=1 in state 7.
- beq with `Zero`=1 → PCEn=1 and PCSrc=01 in state 8. With `Zero`=0 → PCEn=0, then back to FETCH.
- bne `Op`=000101, `Zero`=0:
  - macro defined → states 0,1,8 with PCEn=1 in state 8.
  - macro undefined → states 0,1,0.
- Reset asserted in state 3 of an lw → State=0 asynchronously, before the next edge. No RegWrite is issued; the next instruction fetches cleanly.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// States, opcodes, funct codes, ALUOp and ALUControl values.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decode inputs in, selects and strobes out.
interface multicycle_controller_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCEn;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;
   logic [3:0] State;

   modport master (
      input  Op, Funct, Zero,
      output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, State
   );

   modport slave (
      output Op, Funct, Zero,
      input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, State
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp and Funct to the 3-bit ALU operation, purely combinational.
import mc_pkg::*;

module alu_decoder (
   input  alu_op_t    alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o
);
   always_comb begin
      alu_control_o = ALUC_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_control_o = ALUC_SUB;
         ALUOP_FUNCT: begin
            // unknown funct falls back to add so the R-type still writes rd
            case (funct_i)
               FN_SUB:  alu_control_o = ALUC_SUB;
               FN_AND:  alu_control_o = ALUC_AND;
               FN_OR:   alu_control_o = ALUC_OR;
               FN_SLT:  alu_control_o = ALUC_SLT;
               default: alu_control_o = ALUC_ADD;
            endcase
         end
         default: alu_control_o = ALUC_ADD;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core; outputs decode from State (PCEn also uses Zero).
// Write strobes are held low while reset is asserted. MCCTRL_BNE_EN adds bne support.
import mc_pkg::*;

module multicycle_controller (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_controller_if.master  bus
);
   state_t  state_q, state_d;
   alu_op_t alu_op;
   logic    pc_write, branch, ir_write, reg_write, mem_write;
`ifdef MCCTRL_BNE_EN
   logic    branch_ne;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MCCTRL_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (bus.Op == OP_LW)      state_d = S_MEMREAD;
            else if (bus.Op == OP_SW) state_d = S_MEMWRITE;
            else                      state_d = S_FETCH;
         end
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write     = 1'b0;
      branch       = 1'b0;
`ifdef MCCTRL_BNE_EN
      branch_ne    = 1'b0;
`endif
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      mem_write    = 1'b0;
      bus.IorD     = 1'b0;
      bus.RegDst   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.PCSrc    = 2'b00;
      alu_op       = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            bus.ALUSrcB = 2'b01;
         end
         S_DECODE: bus.ALUSrcB = 2'b11;
         S_MEMADR, S_ADDIEXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMREAD: bus.IorD = 1'b1;
         S_MEMWB: begin
            bus.MemtoReg = 1'b1;
            reg_write    = 1'b1;
         end
         S_MEMWRITE: begin
            bus.IorD  = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            bus.ALUSrcA = 1'b1;
            alu_op      = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            bus.RegDst = 1'b1;
            reg_write  = 1'b1;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_BRANCH: begin
            bus.ALUSrcA = 1'b1;
            alu_op      = ALUOP_SUB;
            bus.PCSrc   = 2'b01;
`ifdef MCCTRL_BNE_EN
            // Op stays in the IR for the whole instruction, so it selects the branch sense
            branch_ne   = (bus.Op == OP_BNE);
            branch      = (bus.Op != OP_BNE);
`else
            branch      = 1'b1;
`endif
         end
         S_JUMP: begin
            bus.PCSrc = 2'b10;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct_i       (bus.Funct),
      .alu_control_o (bus.ALUControl)
   );

`ifdef MCCTRL_BNE_EN
   assign bus.PCEn = reset & (pc_write | (branch & bus.Zero) | (branch_ne & ~bus.Zero));
`else
   assign bus.PCEn = reset & (pc_write | (branch & bus.Zero));
`endif
   assign bus.IRWrite  = reset & ir_write;
   assign bus.RegWrite = reset & reg_write;
   assign bus.MemWrite = reset & mem_write;
   assign bus.State    = state_q;
endmodule
